// File: rtl/uart_tx_frame.sv
// UART transmitter, LSB first, optional parity, 1/2 stop bits; start bit one clock after accept.
// Backpressure: in_ready low while the 1-entry holding register is full; refills back-to-back.
module uart_tx_frame #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [3:0]           bit_idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] hold, hold_n;
  logic [DATA_BITS-1:0] load_word;
  logic                 par_bit, par_n;
  logic                 rdy_n, tx_n, busy_n, done_n;
  logic                 bit_end, load;

  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    idx_n     = bit_idx;
    shift_n   = shift;
    par_n     = par_bit;
    hold_n    = hold;
    rdy_n     = in_ready;
    load      = 1'b0;
    load_word = hold;
    bit_end   = (baud_cnt == BAUD_LAST);

    if (in_valid && in_ready) begin
      hold_n = in_data;
      rdy_n  = 1'b0;
    end

    if (state != S_IDLE) begin
      baud_n = bit_end ? '0 : baud_cnt + BW'(1);
    end

    case (state)
      S_IDLE: begin
        if (!in_ready) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          idx_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_idx == DATA_LAST) begin
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
            idx_n   = '0;
          end else begin
            idx_n = bit_idx + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_n = S_STOP;
          idx_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Last stop clock: a held word, or one accepted right now, starts with no gap.
          if (bit_idx == STOP_LAST) begin
            if (!in_ready) begin
              load = 1'b1;
            end else if (in_valid) begin
              load      = 1'b1;
              load_word = in_data;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            idx_n = bit_idx + 4'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (load) begin
      state_n = S_START;
      baud_n  = '0;
      idx_n   = '0;
      shift_n = load_word;
      par_n   = (PARITY == 2) ? ^load_word : ~^load_word;
      rdy_n   = 1'b1;
    end

    // Outputs are registered copies of what the next state drives.
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      S_PAR:   tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_STOP) && (baud_n == BAUD_LAST) && (idx_n == STOP_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      hold     <= '0;
      par_bit  <= 1'b0;
      in_ready <= 1'b1;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      shift    <= shift_n;
      hold     <= hold_n;
      par_bit  <= par_n;
      in_ready <= rdy_n;
      tx       <= tx_n;
      busy     <= busy_n;
      tx_done  <= done_n;
    end
  end

endmodule
